// File: rtl/pipeline_stall_controller.sv
// Stall/flush control for a 5-stage pipeline with a slow external memory; optional STALL_COUNTER_EN adds a frozen-cycle counter.
// Outputs are combinational in the current cycle; state advances one cycle later.
// A pending memory access holds the whole pipeline until sram_ready, or forever once the wait budget runs out.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             Branch_taken,
    input  logic             Mem_R_EN,
    input  logic             Mem_W_EN,
    input  logic             sram_ready,
    output logic             freeze_IF,
    output logic             flush_IF_ID,
    output logic             bubble_ID_EX,
    output logic             stall_all,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_acc;
    logic       stall_raw;
    logic       freeze_raw, flush_raw, bubble_raw;

    assign mem_acc = Mem_R_EN | Mem_W_EN;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_raw  = 1'b0;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = 8'd0;
                if (mem_acc && !sram_ready) begin
                    stall_raw = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (sram_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    stall_raw = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_TIMEOUT: begin
                stall_raw = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A held pipeline ignores branch/hazard requests; they are re-presented once it moves.
    always_comb begin
        if (stall_raw) begin
            freeze_raw = 1'b1;
            flush_raw  = 1'b0;
            bubble_raw = 1'b0;
        end else begin
            freeze_raw = hazard_detected & ~Branch_taken;
            flush_raw  = Branch_taken;
            bubble_raw = Branch_taken | hazard_detected;
        end
    end

    assign stall_all    = ~rst & stall_raw;
    assign freeze_IF    = ~rst & freeze_raw;
    assign flush_IF_ID  = ~rst & flush_raw;
    assign bubble_ID_EX = ~rst & bubble_raw;
    assign mem_timeout  = ~rst & (state_q == ST_TIMEOUT);
    assign state        = rst ? 2'b00 : state_q;

`ifdef STALL_COUNTER_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (freeze_IF && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = rst ? '0 : stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a cycle-level reference model.
module tb_pipeline_stall_controller;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 2;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;
`ifdef STALL_COUNTER_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hazard_detected = 1'b0;
    logic             Branch_taken = 1'b0;
    logic             Mem_R_EN = 1'b0;
    logic             Mem_W_EN = 1'b0;
    logic             sram_ready = 1'b0;
    logic             freeze_IF, flush_IF_ID, bubble_ID_EX, stall_all, mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hazard_detected(hazard_detected),
        .Branch_taken   (Branch_taken),
        .Mem_R_EN       (Mem_R_EN),
        .Mem_W_EN       (Mem_W_EN),
        .sram_ready     (sram_ready),
        .freeze_IF      (freeze_IF),
        .flush_IF_ID    (flush_IF_ID),
        .bubble_ID_EX   (bubble_ID_EX),
        .stall_all      (stall_all),
        .mem_timeout    (mem_timeout),
        .state          (state),
        .stall_count    (stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access that keeps stalling for MEM_TIMEOUT+1 consecutive cycles kills the pipeline.
    bit         m_busy = 1'b0;
    bit         m_dead = 1'b0;
    int         m_stalls = 0;
    int         m_cnt = 0;
    logic       e_stall, e_freeze, e_flush, e_bubble, e_to;
    logic [1:0] e_state;
    int         e_cnt;

    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                e_stall = 0; e_freeze = 0; e_flush = 0; e_bubble = 0; e_to = 0;
                e_state = 2'd0; e_cnt = 0;
            end else begin
                e_stall = m_dead | (!sram_ready & (m_busy | Mem_R_EN | Mem_W_EN));
                if (e_stall) begin
                    e_freeze = 1; e_flush = 0; e_bubble = 0;
                end else begin
                    e_flush  = Branch_taken;
                    e_bubble = Branch_taken | hazard_detected;
                    e_freeze = hazard_detected & !Branch_taken;
                end
                e_state = m_dead ? 2'd2 : (m_busy ? 2'd1 : 2'd0);
                e_to    = m_dead;
                e_cnt   = CNT_ON ? m_cnt : 0;
            end
            chk("m_stall_all", 32'(stall_all), 32'(e_stall));
            chk("m_freeze_IF", 32'(freeze_IF), 32'(e_freeze));
            chk("m_flush_IF_ID", 32'(flush_IF_ID), 32'(e_flush));
            chk("m_bubble_ID_EX", 32'(bubble_ID_EX), 32'(e_bubble));
            chk("m_mem_timeout", 32'(mem_timeout), 32'(e_to));
            chk("m_state", 32'(state), 32'(e_state));
            chk("m_stall_count", 32'(stall_count), 32'(e_cnt));
            if (rst) begin
                m_busy = 0; m_dead = 0; m_stalls = 0; m_cnt = 0;
            end else begin
                if (e_freeze && m_cnt < CNT_MAX) m_cnt++;
                if (!m_dead) begin
                    if (e_stall) begin
                        m_stalls++;
                        m_busy = 1;
                        if (m_stalls == int'(MEM_TIMEOUT) + 1) m_dead = 1;
                    end else begin
                        m_stalls = 0;
                        m_busy = 0;
                    end
                end
            end
        end
    end

    task automatic apply(input bit r, input bit h, input bit b, input bit mr, input bit mw, input bit rdy);
        @(posedge clk);
        #1;
        rst = r; hazard_detected = h; Branch_taken = b;
        Mem_R_EN = mr; Mem_W_EN = mw; sram_ready = rdy;
        started = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input bit fr, input bit fl, input bit bu,
                              input bit st, input logic [1:0] s);
        chk({tag, ".freeze_IF"}, 32'(freeze_IF), 32'(fr));
        chk({tag, ".flush_IF_ID"}, 32'(flush_IF_ID), 32'(fl));
        chk({tag, ".bubble_ID_EX"}, 32'(bubble_ID_EX), 32'(bu));
        chk({tag, ".stall_all"}, 32'(stall_all), 32'(st));
        chk({tag, ".state"}, 32'(state), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        apply(1, 0, 0, 0, 0, 0); sample();
        expect_ctl("reset", 0, 0, 0, 0, 2'd0);
        chk("reset.mem_timeout", 32'(mem_timeout), 32'd0);
        chk("reset.stall_count", 32'(stall_count), 32'd0);

        // Hazard / branch priority
        apply(0, 1, 0, 0, 0, 0); sample(); expect_ctl("hazard", 1, 0, 1, 0, 2'd0);
        apply(0, 1, 1, 0, 0, 0); sample(); expect_ctl("haz_br", 0, 1, 1, 0, 2'd0);
        apply(0, 0, 1, 0, 0, 0); sample(); expect_ctl("branch", 0, 1, 1, 0, 2'd0);
        apply(0, 0, 0, 0, 0, 1); sample(); expect_ctl("idle", 0, 0, 0, 0, 2'd0);

        // Load waits three cycles with a branch held
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1, 0, 0); sample();
            expect_ctl("ld_wait", 1, 0, 0, 1, (i == 0) ? 2'd0 : 2'd1);
        end
        apply(0, 0, 1, 1, 0, 1); sample(); expect_ctl("ld_release", 0, 1, 1, 0, 2'd1);
        apply(0, 0, 0, 0, 0, 1); sample(); expect_ctl("ld_after", 0, 0, 0, 0, 2'd0);

        // Store that hits immediately
        apply(0, 0, 0, 0, 1, 1); sample(); expect_ctl("st_hit", 0, 0, 0, 0, 2'd0);

        // Hazard during a memory stall, then on release
        apply(0, 1, 0, 1, 0, 0); sample(); expect_ctl("haz_in_stall", 1, 0, 0, 1, 2'd0);
        apply(0, 1, 0, 1, 0, 1); sample(); expect_ctl("haz_release", 1, 0, 1, 0, 2'd1);
        apply(0, 0, 0, 0, 0, 1); sample();

        // Reset in the middle of a memory wait
        apply(0, 0, 0, 1, 0, 0); sample();
        apply(0, 0, 0, 1, 0, 0); sample(); expect_ctl("pre_rst_wait", 1, 0, 0, 1, 2'd1);
        apply(1, 0, 0, 1, 0, 0); sample(); expect_ctl("rst_in_wait", 0, 0, 0, 0, 2'd0);
        apply(0, 0, 0, 0, 0, 1); sample(); expect_ctl("after_rst_wait", 0, 0, 0, 0, 2'd0);

        // Timeout: store never completes
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0, 1, 0); sample();
            chk("to_seq.state", 32'(state), (i == 0) ? 32'd0 : ((i < 5) ? 32'd1 : 32'd2));
            chk("to_seq.stall_all", 32'(stall_all), 32'd1);
            chk("to_seq.mem_timeout", 32'(mem_timeout), (i == 5) ? 32'd1 : 32'd0);
        end
        apply(0, 1, 1, 0, 0, 1); sample(); expect_ctl("to_sticky", 1, 0, 0, 1, 2'd2);
        chk("to_sticky.mem_timeout", 32'(mem_timeout), 32'd1);
        apply(1, 0, 0, 0, 1, 0); sample(); expect_ctl("rst_in_to", 0, 0, 0, 0, 2'd0);
        chk("rst_in_to.mem_timeout", 32'(mem_timeout), 32'd0);
        apply(0, 0, 0, 0, 0, 1); sample(); expect_ctl("after_rst_to", 0, 0, 0, 0, 2'd0);
        chk("after_rst_to.mem_timeout", 32'(mem_timeout), 32'd0);

        // Saturating frozen-cycle counter
        apply(1, 0, 0, 0, 0, 0); sample();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 0, 0, 0); sample();
            if (i > 0) chk("cnt_seq", 32'(stall_count), CNT_ON ? 32'((i > 3) ? 3 : i) : 32'd0);
        end
        apply(0, 0, 0, 0, 0, 1); sample();
        chk("cnt_final", 32'(stall_count), CNT_ON ? 32'd3 : 32'd0);

        apply(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
